// File: rtl/loader_pkg.sv
// Shared encodings for the program loader: FSM states, opcode constants, default store depth.
package loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CHK  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam logic [7:0] OP_HLT        = 8'hFF;
   localparam logic [7:0] OP_NOP        = 8'h00;
   localparam int         DEPTH_DEFAULT = 16;

endpackage

// File: rtl/prog_mem.sv
// Program store: DEPTH x DW register array, single-cycle clear to a fill word,
// one synchronous write port and an asynchronous read port.
module prog_mem #(
   parameter int              DEPTH     = 16,
   parameter int              AW        = 4,
   parameter int              DW        = 8,
   parameter logic [DW-1:0]   FILL_WORD = '1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          clr_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_w [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
         logic [DW-1:0] word_q;

         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
               word_q <= FILL_WORD;
            end else if (clr_i) begin
               word_q <= FILL_WORD;
            end else if (we_i && (waddr_i == AW'(gi))) begin
               word_q <= wdata_i;
            end
         end

         assign mem_w[gi] = word_q;
      end
   endgenerate

   assign rdata_o = mem_w[raddr_i];

endmodule

// File: rtl/program_loader.sv
// Byte-stream program loader for the accumulator CPU: fills the store, serves fetches, holds the CPU.
// Optional trailing checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader
   import loader_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int AW    = 4,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data,
   output logic          cpu_hold,
   output logic          load_done,
   output logic [AW:0]   count,
   output logic          err
);

   state_e        state_q, state_d;
   logic [AW:0]   count_q, count_d;
   logic          accept;
   logic          last_byte;
   logic          mem_clr;
   logic          mem_we;
   logic [DW-1:0] mem_rdata;
   logic          err_flag;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [DW-1:0] sum_q, sum_d;
   logic [DW-1:0] chk_total;
   logic          err_q, err_d;

   assign chk_total = sum_q + in_data;
   assign err_flag  = err_q;
`else
   assign err_flag  = 1'b0;
`endif

   assign in_ready  = (state_q == ST_LOAD) || (state_q == ST_CHK);
   assign accept    = in_valid && in_ready;
   // The DEPTH-th byte terminates the load even if it is not HLT, so wr_ptr never wraps.
   assign last_byte = (in_data == DW'(OP_HLT)) || (count_q == (AW+1)'(DEPTH - 1));

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mem_clr = 1'b0;
      mem_we  = 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
      err_d   = err_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_LOAD;
               count_d = '0;
               mem_clr = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               sum_d   = '0;
               err_d   = 1'b0;
`endif
            end
         end
         ST_LOAD: begin
            if (accept) begin
               mem_we = 1'b1;
               if (count_q < (AW+1)'(DEPTH)) begin
                  count_d = count_q + 1'b1;
               end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               sum_d = sum_q + in_data;
               if (last_byte) begin
                  state_d = ST_CHK;
               end
`else
               if (last_byte) begin
                  state_d = ST_DONE;
               end
`endif
            end
         end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (accept) begin
               err_d   = (chk_total != '0);
               state_d = ST_DONE;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         count_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         sum_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
         err_q   <= err_d;
`endif
      end
   end

   prog_mem #(
      .DEPTH     (DEPTH),
      .AW        (AW),
      .DW        (DW),
      .FILL_WORD (DW'(OP_HLT))
   ) u_prog_mem (
      .clk     (clk),
      .rstn    (rstn),
      .clr_i   (mem_clr),
      .we_i    (mem_we),
      .waddr_i (count_q[AW-1:0]),
      .wdata_i (in_data),
      .raddr_i (rd_addr),
      .rdata_o (mem_rdata)
   );

   assign rd_data   = (state_q == ST_DONE) ? mem_rdata : DW'(OP_NOP);
   assign load_done = (state_q == ST_DONE) && !err_flag;
   assign cpu_hold  = !load_done;
   assign count     = count_q;
   assign err       = err_flag;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader; checksum scenario runs when
// PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       rstn;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;
   logic       cpu_hold;
   logic       load_done;
   logic [4:0] count;
   logic       err;

   int         pass_cnt  = 0;
   int         total_cnt = 0;
   logic [7:0] sum_model;
   logic [7:0] exp_mem [16];

   program_loader dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .cpu_hold  (cpu_hold),
      .load_done (load_done),
      .count     (count),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      start = 1'b1;
      tick();
      start = 1'b0;
      sum_model = 8'h00;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && guard < 20) begin
         tick();
         guard++;
      end
      total_cnt++;
      if (guard >= 20) begin
         $display("FAIL send_byte_%02h: in_ready stayed 0, required 1", b);
      end else begin
         pass_cnt++;
         sum_model = sum_model + b;
         tick();
      end
      in_valid = 1'b0;
   endtask

   // Sends the checksum byte when the checksum stage exists; nothing otherwise.
   task automatic finish_load();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(8'h00 - sum_model);
`endif
   endtask

   task automatic check_mem(input string tag);
      for (int a = 0; a < 16; a++) begin
         rd_addr = 4'(a);
         #1;
         total_cnt++;
         if (rd_data !== exp_mem[a]) begin
            $display("FAIL %s_mem[%0d]: got %02h, required %02h", tag, a, rd_data, exp_mem[a]);
         end else begin
            pass_cnt++;
         end
      end
   endtask

   task automatic check_done(input string tag, input logic [4:0] exp_cnt);
      total_cnt++;
      if (count !== exp_cnt || load_done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
         $display("FAIL %s_done: count=%0d load_done=%b cpu_hold=%b in_ready=%b, required %0d 1 0 0",
                  tag, count, load_done, cpu_hold, in_ready, exp_cnt);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      rd_addr = 4'd3;
      #1;
      total_cnt++;
      if (cpu_hold !== 1'b1 || in_ready !== 1'b0 || load_done !== 1'b0 || count !== 5'd0 ||
          rd_data !== 8'h00 || err !== 1'b0) begin
         $display("FAIL reset: hold=%b rdy=%b done=%b cnt=%0d rd=%02h err=%b, required 1 0 0 0 00 0",
                  cpu_hold, in_ready, load_done, count, rd_data, err);
      end else begin
         pass_cnt++;
      end
      tick();
      tick();
      rstn = 1'b1;
      tick();
      total_cnt++;
      if (in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
         $display("FAIL idle_after_reset: rdy=%b hold=%b, required 0 1", in_ready, cpu_hold);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic test_basic_load();
      start_load();
      total_cnt++;
      if (in_ready !== 1'b1 || rd_data !== 8'h00 || cpu_hold !== 1'b1) begin
         $display("FAIL load_entry: rdy=%b rd=%02h hold=%b, required 1 00 1", in_ready, rd_data, cpu_hold);
      end else begin
         pass_cnt++;
      end
      send_byte(8'h93);
      send_byte(8'h63);
      send_byte(8'h15);
      send_byte(8'hFF);
      finish_load();
      check_done("basic", 5'd4);
      for (int a = 0; a < 16; a++) exp_mem[a] = 8'hFF;
      exp_mem[0] = 8'h93;
      exp_mem[1] = 8'h63;
      exp_mem[2] = 8'h15;
      check_mem("basic");
   endtask

   task automatic test_full_depth();
      start_load();
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b0;
         tick();
         send_byte(8'(i));
      end
      finish_load();
      in_valid = 1'b1;
      in_data  = 8'h11;
      #1;
      total_cnt++;
      if (in_ready !== 1'b0) begin
         $display("FAIL byte17_ready: got %b, required 0", in_ready);
      end else begin
         pass_cnt++;
      end
      tick();
      tick();
      in_valid = 1'b0;
      check_done("full", 5'd16);
      for (int a = 0; a < 16; a++) exp_mem[a] = 8'(a + 1);
      check_mem("full");
   endtask

   task automatic test_reload();
      start_load();
      send_byte(8'hA0);
      send_byte(8'hFF);
      finish_load();
      check_done("reload", 5'd2);
      for (int a = 0; a < 16; a++) exp_mem[a] = 8'hFF;
      exp_mem[0] = 8'hA0;
      check_mem("reload");
   endtask

   task automatic test_start_and_reset_mid_load();
      start_load();
      send_byte(8'hAA);
      start = 1'b1;
      send_byte(8'hBB);
      start = 1'b0;
      total_cnt++;
      if (count !== 5'd2 || in_ready !== 1'b1) begin
         $display("FAIL start_ignored: count=%0d rdy=%b, required 2 1", count, in_ready);
      end else begin
         pass_cnt++;
      end
      send_byte(8'hCC);
      send_byte(8'hFF);
      finish_load();
      check_done("start_ign", 5'd4);
      for (int a = 0; a < 16; a++) exp_mem[a] = 8'hFF;
      exp_mem[0] = 8'hAA;
      exp_mem[1] = 8'hBB;
      exp_mem[2] = 8'hCC;
      check_mem("start_ign");

      start_load();
      send_byte(8'h11);
      send_byte(8'h22);
      #2;
      rstn = 1'b0;
      #1;
      total_cnt++;
      if (count !== 5'd0 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || load_done !== 1'b0) begin
         $display("FAIL midload_reset: count=%0d hold=%b rdy=%b done=%b, required 0 1 0 0",
                  count, cpu_hold, in_ready, load_done);
      end else begin
         pass_cnt++;
      end
      tick();
      rstn = 1'b1;
      tick();
      start_load();
      send_byte(8'hFF);
      finish_load();
      check_done("after_rst", 5'd1);
      for (int a = 0; a < 16; a++) exp_mem[a] = 8'hFF;
      check_mem("after_rst");
   endtask

   task automatic test_checksum();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      start_load();
      send_byte(8'h10);
      send_byte(8'h20);
      send_byte(8'hFF);
      total_cnt++;
      if (in_ready !== 1'b1 || count !== 5'd3 || cpu_hold !== 1'b1) begin
         $display("FAIL chk_state: rdy=%b count=%0d hold=%b, required 1 3 1", in_ready, count, cpu_hold);
      end else begin
         pass_cnt++;
      end
      send_byte(8'hD1);
      total_cnt++;
      if (err !== 1'b0 || load_done !== 1'b1 || cpu_hold !== 1'b0 || count !== 5'd3) begin
         $display("FAIL chk_good: err=%b done=%b hold=%b count=%0d, required 0 1 0 3",
                  err, load_done, cpu_hold, count);
      end else begin
         pass_cnt++;
      end
      start_load();
      send_byte(8'h10);
      send_byte(8'h20);
      send_byte(8'hFF);
      send_byte(8'h00);
      total_cnt++;
      if (err !== 1'b1 || load_done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
         $display("FAIL chk_bad: err=%b done=%b hold=%b rdy=%b, required 1 0 1 0",
                  err, load_done, cpu_hold, in_ready);
      end else begin
         pass_cnt++;
      end
`else
      total_cnt++;
      if (err !== 1'b0) begin
         $display("FAIL err_tied: got %b, required 0", err);
      end else begin
         pass_cnt++;
      end
`endif
   endtask

   initial begin
      rstn      = 1'b0;
      start     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      rd_addr   = 4'd0;
      sum_model = 8'h00;
      test_reset();
      test_basic_load();
      test_full_depth();
      test_reload();
      test_start_and_reset_mid_load();
      test_checksum();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
